// File: rtl/fpu_pkg.sv
// Shared FPU definitions: IEEE-754 single field widths, exponent bias and
// the packed float layout used by the floor, ftoi and itof units.
package fpu_pkg;

   localparam int FP_BIAS = 127;
   localparam int EXP_W   = 8;
   localparam int FRAC_W  = 23;

   typedef struct packed {
      logic              s;
      logic [EXP_W-1:0]  e;
      logic [FRAC_W-1:0] m;
   } float_t;

   localparam float_t FLOAT_POS_ZERO = '{s: 1'b0, e: '0, m: '0};

   function automatic float_t pack_float(input logic              s,
                                         input logic [EXP_W-1:0]  e,
                                         input logic [FRAC_W-1:0] m);
      float_t f;
      f.s = s;
      f.e = e;
      f.m = m;
      return f;
   endfunction

endpackage

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter; an all-zero input yields 32.
module lzc32 (
   input  logic [31:0] a_i,
   output logic [5:0]  cnt_o
);

   // NOTE: cnt_o gets a default before the loop so no path leaves it unassigned (no latch).
   always_comb begin
      cnt_o = 6'd32;
      // Scanning upward lets the highest set bit write last and win.
      for (int i = 0; i < 32; i++) begin
         if (a_i[i]) begin
            cnt_o = 6'(31 - i);
         end
      end
   end

endmodule

// File: rtl/itof_pipe.sv
// Two-stage int32 -> IEEE-754 single converter, round-to-nearest-even,
// with valid/stall/flush control shared with the other fixed-latency FPU lanes.
module itof_pipe
   import fpu_pkg::*;
#(
   parameter bit SIGNED = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] x,
   input  logic        stall,
   input  logic        flush,
   output logic        out_valid,
   output logic [31:0] y
);

   localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(FP_BIAS + 31);

   // Stage 1: sign/magnitude split and normalisation shift amount.
   logic        sign_d;
   logic [31:0] mag_d;
   logic [5:0]  lz_d;
   logic        z_d;

   logic        v1_q;
   logic        sign_q;
   logic [31:0] mag_q;
   logic [5:0]  lz_q;
   logic        z_q;

   assign sign_d = SIGNED && x[31];
   assign mag_d  = sign_d ? (~x + 32'd1) : x;
   assign z_d    = (mag_d == '0);

   lzc32 u_lzc (
      .a_i   (mag_d),
      .cnt_o (lz_d)
   );

   // Stage 2: normalise, round to nearest even, pack.
   logic [30:0]       norm;
   logic              guard;
   logic              sticky;
   logic              round_up;
   logic              carry;
   logic [FRAC_W-1:0] mant;
   float_t            res;
   logic [31:0]       y_d;

   logic              v2_q;
   logic [31:0]       y_q;

   always_comb begin
      // The implicit leading one (bit 31) is dropped here; a zero operand is handled by z_q.
      norm          = 31'(mag_q << lz_q);
      guard         = norm[7];
      sticky        = |norm[6:0];
      round_up      = guard & (sticky | norm[8]);
      {carry, mant} = {1'b0, norm[30:8]} + 24'(round_up);
      res           = pack_float(sign_q,
                                 EXP_TOP - EXP_W'(lz_q) + EXP_W'(carry),
                                 mant);
      if (z_q) begin
         res = FLOAT_POS_ZERO;
      end
      y_d = res;
   end

   // NOTE: pipeline state uses non-blocking assignments so each stage samples the pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         sign_q <= 1'b0;
         mag_q  <= '0;
         lz_q   <= '0;
         z_q    <= 1'b0;
         y_q    <= '0;
      end else if (flush) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
      end else if (!stall) begin
         v1_q <= in_valid;
         v2_q <= v1_q;
         if (in_valid) begin
            sign_q <= sign_d;
            mag_q  <= mag_d;
            lz_q   <= lz_d;
            z_q    <= z_d;
         end
         // Bubbles leave the last valid result on y.
         if (v1_q) begin
            y_q <= y_d;
         end
      end
   end

   assign out_valid = v2_q;
   assign y         = y_q;

endmodule

// File: tb/tb_itof_pipe.sv
// Directed bench for itof_pipe: a signed and an unsigned instance share one
// stimulus stream; table vectors plus hand-written stall/flush/reset sequences.
module tb_itof_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] x;
   logic        stall;
   logic        flush;
   logic        out_valid_s;
   logic [31:0] y_s;
   logic        out_valid_u;
   logic [31:0] y_u;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   itof_pipe #(.SIGNED(1'b1)) u_dut_s (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .x         (x),
      .stall     (stall),
      .flush     (flush),
      .out_valid (out_valid_s),
      .y         (y_s)
   );

   itof_pipe #(.SIGNED(1'b0)) u_dut_u (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .x         (x),
      .stall     (stall),
      .flush     (flush),
      .out_valid (out_valid_u),
      .y         (y_u)
   );

   typedef struct {
      logic [31:0] x;
      logic [31:0] y_signed;
      logic [31:0] y_unsigned;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %08h, expected %08h", name, act, exp);
      end
   endtask

   // Advance one edge, then settle away from it before sampling or driving.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] d);
      in_valid = v;
      x        = d;
   endtask

   vec_t vecs[10];

   initial begin
      vecs[0] = '{32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000};
      vecs[1] = '{32'hFFFF_FFFF, 32'hBF80_0000, 32'h4F80_0000};
      vecs[2] = '{32'h0000_0003, 32'h4040_0000, 32'h4040_0000};
      vecs[3] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
      vecs[4] = '{32'h8000_0000, 32'hCF00_0000, 32'h4F00_0000};
      vecs[5] = '{32'h7FFF_FFFF, 32'h4F00_0000, 32'h4F00_0000};
      vecs[6] = '{32'h0100_0000, 32'h4B80_0000, 32'h4B80_0000};
      vecs[7] = '{32'd16777217,  32'h4B80_0000, 32'h4B80_0000};
      vecs[8] = '{32'd16777219,  32'h4B80_0002, 32'h4B80_0002};
      vecs[9] = '{32'd16777221,  32'h4B80_0002, 32'h4B80_0002};

      rst   = 1'b1;
      stall = 1'b0;
      flush = 1'b0;
      drive(1'b0, 32'h0);
      tick();
      tick();
      check("reset out_valid", {31'b0, out_valid_s}, 32'h0);
      check("reset y", y_s, 32'h0);
      check("reset y unsigned", y_u, 32'h0);
      rst = 1'b0;

      // Back-to-back stream: result for vector i-1 appears after edge i.
      for (int i = 0; i < 12; i++) begin
         if (i < 10) drive(1'b1, vecs[i].x);
         else        drive(1'b0, 32'h0);
         tick();
         if (i == 0) begin
            check("latency out_valid low", {31'b0, out_valid_s}, 32'h0);
         end else if (i <= 10) begin
            check($sformatf("vec%0d out_valid", i - 1), {31'b0, out_valid_s}, 32'h1);
            check($sformatf("vec%0d y signed", i - 1), y_s, vecs[i - 1].y_signed);
            check($sformatf("vec%0d y unsigned", i - 1), y_u, vecs[i - 1].y_unsigned);
         end else begin
            check("bubble out_valid", {31'b0, out_valid_s}, 32'h0);
            check("bubble y holds", y_s, vecs[9].y_signed);
         end
      end

      // Stall with B=7 in stage 1 and A=5 on the output; new input is ignored.
      drive(1'b1, 32'd5);
      tick();
      drive(1'b1, 32'd7);
      tick();
      check("A out_valid", {31'b0, out_valid_s}, 32'h1);
      check("A y", y_s, 32'h40A0_0000);
      stall = 1'b1;
      drive(1'b1, 32'd9);
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("stall%0d out_valid", k), {31'b0, out_valid_s}, 32'h1);
         check($sformatf("stall%0d y", k), y_s, 32'h40A0_0000);
      end
      stall = 1'b0;
      drive(1'b0, 32'h0);
      tick();
      check("B out_valid", {31'b0, out_valid_s}, 32'h1);
      check("B y", y_s, 32'h40E0_0000);
      tick();
      check("after B out_valid", {31'b0, out_valid_s}, 32'h0);
      check("after B y holds", y_s, 32'h40E0_0000);

      // Flush kills an in-flight op and drops the operand presented with it.
      drive(1'b1, 32'd1);
      tick();
      flush = 1'b1;
      drive(1'b1, 32'd3);
      tick();
      flush = 1'b0;
      drive(1'b0, 32'h0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("flush%0d out_valid", k), {31'b0, out_valid_s}, 32'h0);
      end

      // Flush overrides a simultaneous stall.
      drive(1'b1, 32'd2);
      tick();
      flush = 1'b1;
      stall = 1'b1;
      drive(1'b1, 32'd3);
      tick();
      flush = 1'b0;
      stall = 1'b0;
      drive(1'b0, 32'h0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("flush+stall%0d out_valid", k), {31'b0, out_valid_s}, 32'h0);
      end

      // Reset mid-stream: operand 2 is in stage 1 and 3 is on x when rst hits.
      drive(1'b1, 32'd1);
      tick();
      drive(1'b1, 32'd2);
      tick();
      check("pre-rst out_valid", {31'b0, out_valid_s}, 32'h1);
      check("pre-rst y", y_s, 32'h3F80_0000);
      rst = 1'b1;
      drive(1'b1, 32'd3);
      tick();
      rst = 1'b0;
      drive(1'b0, 32'h0);
      check("post-rst out_valid", {31'b0, out_valid_s}, 32'h0);
      check("post-rst y", y_s, 32'h0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("post-rst%0d out_valid", k), {31'b0, out_valid_s}, 32'h0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
